muxn_rr_sel: RTL
================

Name: muxn_rr_sel

Overview:
Parametrised N-channel, WIDTH-bit selector; successor to the combinational 2:1 mux in the datapath library.
- Adds valid/ready handshakes on every input and on the output.
- Holds the selected word in a registered output stage.
- Two modes: fixed-select (external sel) or round-robin among valid channels.
- Used wherever several producers share one downstream consumer.

Parameters:
WIDTH, 8, data width per channel
CHANNELS, 4, number of input channels (2..16)
SELW, 2, select/channel-index width; equals ceil(log2(CHANNELS))

Ports:
clk  input  1  clock, rising edge
reset  input  1  reset, synchronous, active-low
mode  input  1  0 = fixed-select, 1 = round-robin
sel  input  SELW  channel index used in fixed mode
in_data  input  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
in_valid  input  CHANNELS  per-channel valid
in_ready  output  CHANNELS  per-channel ready (one-hot or zero)
out_data  output  WIDTH  registered selected word
out_valid  output  1  out_data holds a word
out_ready  input  1  consumer accepts
out_chan  output  SELW  source channel of out_data

Behaviour:
- Reset (reset=0 at rising clk): out_valid=0, out_data=0, out_chan=0, rr pointer ptr=0. Reset overrides any transfer that cycle; a word held mid-handshake is discarded.
- Output register state:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - load_en = ~out_valid | out_ready, combinational.
  - Gives full throughput: a word drains and a new word loads in the same cycle.
- Grant selection (combinational, each cycle):
  - Fixed mode: grant channel sel iff sel < CHANNELS and in_valid[sel]=1. If sel >= CHANNELS, no grant.
  - Round-robin mode: grant the first i with in_valid[i]=1, scanning ptr, ptr+1, ... mod CHANNELS. No valid input means no grant.
- Handshakes:
  - in_ready[g] = load_en for the granted channel g; all other in_ready bits are 0.
  - in_ready never depends on in_valid of a non-granted channel.
- Transfer on channel g = in_valid[g] & in_ready[g]. At the clock edge: out_data <= in_data[g], out_chan <= g, out_valid <= 1.
- If out_valid & out_ready and no input transfer occurs: out_valid <= 0. out_data and out_chan hold their last values.
- Latency: one cycle from input transfer to out_valid.
- Output stability: while out_valid=1 & out_ready=0, out_data and out_chan must not change.
- Pointer update:
  - ptr <= (g+1) mod CHANNELS on every input transfer, in either mode.
  - Wrap: a grant to CHANNELS-1 sets ptr=0.
  - ptr holds when there is no transfer.
- Mode or sel change: takes effect combinationally on the next grant decision. A word already in the output register is unaffected.
- Simultaneous multiple valids (round-robin): only one grant per cycle. The others wait, with in_valid held by the producer per handshake rules.
- in_valid deasserted without a transfer: legal; no state change.

Optional Feature:
MUXN_XFER_CNT_EN
- Defined:
  - Adds output port xfer_cnt (16 bits).
  - Increments by 1 on each output transfer (out_valid & out_ready).
  - Saturates at 16'hFFFF.
  - Cleared to 0 by reset.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, all in_valid=0, then release -> out_valid=0, out_data=0, out_chan=0, in_ready=4'b0000.
- Fixed mode, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_chan=2.
- Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles; out_chan follows one cycle later.
- Backpressure: out holds 8'h3C (ch1), out_ready=0 for 3 cycles with ch0 valid -> in_ready=0, out_data stays 8'h3C. On out_ready=1, ch0 is accepted the same cycle and out_data changes the next cycle.
- Invalid select: mode=0, sel=3 with CHANNELS=3, in_valid=3'b111 -> in_ready=0, out_valid stays 0.
- Reset mid-operation: out_valid=1, out_data=8'h77, ptr=2; assert reset=0 for one cycle -> out_valid=0, out_data=0, and the next round-robin grant with all valid is ch0. With MUXN_XFER_CNT_EN defined, xfer_cnt=0.

Source files
------------

// File: rtl/muxn_rr_sel.sv
// N-channel valid/ready selector with a registered output stage; fixed-select or round-robin grant.
// Optional MUXN_XFER_CNT_EN adds a saturating 16-bit output-transfer counter (xfer_cnt).
module muxn_rr_sel #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SELW-1:0]           out_chan
`ifdef MUXN_XFER_CNT_EN
  ,
  output logic [15:0]               xfer_cnt
`endif
);

  localparam logic [SELW:0] CH_EXT = (SELW+1)'(CHANNELS);

  logic [WIDTH-1:0] chan_data [CHANNELS];
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             load_en;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic [SELW:0]    rr_idx;
  logic             xfer;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign load_en = ~out_valid_q | out_ready;

  // Round-robin scans from ptr downward in priority; iterating backwards lets the nearest valid win.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = '0;
    if (!mode) begin
      if (({1'b0, sel} < CH_EXT) && in_valid[sel]) begin
        grant_vld = 1'b1;
        grant_idx = sel;
      end
    end else begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        rr_idx = {1'b0, ptr_q} + (SELW+1)'(k);
        if (rr_idx >= CH_EXT) begin
          rr_idx = rr_idx - CH_EXT;
        end
        if (in_valid[rr_idx[SELW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = rr_idx[SELW-1:0];
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = load_en & grant_vld & (grant_idx == SELW'(i));
    end
  end

  assign xfer = load_en & grant_vld;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = chan_data[grant_idx];
      out_chan_d  = grant_idx;
      ptr_d       = (grant_idx == SELW'(CHANNELS - 1)) ? '0 : grant_idx + SELW'(1);
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

`ifdef MUXN_XFER_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_q & out_ready & (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule
